// File: rtl/fb_module_if.sv
// fb_module_if: host-side port-B bus for the four gain LUTs of fb_module.
//
// Signals (N = 1, 2; one set per LUT bpmN_i / bpmN_q):
//   bpmN_{i,q}_lut_dinb  [6:0]  write data         (host -> LUT)
//   bpmN_{i,q}_lut_addrb [14:0] address            (host -> LUT)
//   bpmN_{i,q}_lut_web          write enable       (host -> LUT)
//   bpmN_{i,q}_lut_doutb [6:0]  registered readout (LUT -> host)
//
// Handshake: there is no valid/ready pair. An access happens on the clk where
// the host strobe slow_clk is seen rising; addrb/dinb/web are sampled on that
// clk, doutb carries the read-first data from the next clk on and holds until
// the next access.
interface fb_module_if;
  logic [6:0]  bpm1_i_lut_dinb,  bpm1_q_lut_dinb,  bpm2_i_lut_dinb,  bpm2_q_lut_dinb;
  logic [14:0] bpm1_i_lut_addrb, bpm1_q_lut_addrb, bpm2_i_lut_addrb, bpm2_q_lut_addrb;
  logic        bpm1_i_lut_web,   bpm1_q_lut_web,   bpm2_i_lut_web,   bpm2_q_lut_web;
  logic [6:0]  bpm1_i_lut_doutb, bpm1_q_lut_doutb, bpm2_i_lut_doutb, bpm2_q_lut_doutb;

  modport master (
    output bpm1_i_lut_dinb,  bpm1_q_lut_dinb,  bpm2_i_lut_dinb,  bpm2_q_lut_dinb,
    output bpm1_i_lut_addrb, bpm1_q_lut_addrb, bpm2_i_lut_addrb, bpm2_q_lut_addrb,
    output bpm1_i_lut_web,   bpm1_q_lut_web,   bpm2_i_lut_web,   bpm2_q_lut_web,
    input  bpm1_i_lut_doutb, bpm1_q_lut_doutb, bpm2_i_lut_doutb, bpm2_q_lut_doutb
  );

  modport slave (
    input  bpm1_i_lut_dinb,  bpm1_q_lut_dinb,  bpm2_i_lut_dinb,  bpm2_q_lut_dinb,
    input  bpm1_i_lut_addrb, bpm1_q_lut_addrb, bpm2_i_lut_addrb, bpm2_q_lut_addrb,
    input  bpm1_i_lut_web,   bpm1_q_lut_web,   bpm2_i_lut_web,   bpm2_q_lut_web,
    output bpm1_i_lut_doutb, bpm1_q_lut_doutb, bpm2_i_lut_doutb, bpm2_q_lut_doutb
  );
endinterface

// File: rtl/fb_module.sv
// fb_module: FONT5 beam-position feedback datapath.
//
// Ports:
//   clk, rst         sole clock; synchronous active-high reset
//   slow_clk         host strobe, sampled as data; a rising edge enables one
//                    port-B access on every LUT
//   sel[1:0]         00 zero, 01 q_signal, 10 feedback, 11 feedback + q_signal
//   ai/aq_in         charge channel, forms the LUT address
//   bi/bq/ci/cq_in   BPM1 / BPM2 I/Q samples (13-bit signed)
//   q_signal         auxiliary feed-forward sample (13-bit signed)
//   store_strb       beam window
//   b1_strobe[9:0]   signed offset from window start to bunch 1 (<0 means 0)
//   delay_en         adds four cycles of output delay
//   lut_bus          port-B bus of the four gain LUTs (slave side)
//   fb_sgnl          registered 13-bit signed kicker drive
//
// Pipeline: stage1 input regs -> stage2 LUT read -> stage3 products ->
// stage4 sum -> stage5 output (5 clk), optionally +4 delay registers (9 clk).
module fb_module (
  input  logic               clk,
  input  logic               rst,
  input  logic               slow_clk,
  input  logic [1:0]         sel,
  input  logic signed [12:0] ai_in,
  input  logic signed [12:0] aq_in,
  input  logic signed [12:0] bi_in,
  input  logic signed [12:0] bq_in,
  input  logic signed [12:0] ci_in,
  input  logic signed [12:0] cq_in,
  input  logic signed [12:0] q_signal,
  input  logic               store_strb,
  input  logic signed [9:0]  b1_strobe,
  input  logic               delay_en,
  fb_module_if.slave         lut_bus,
  output logic signed [12:0] fb_sgnl
);

  function automatic logic signed [12:0] sat13(input logic signed [16:0] x);
    if (x > 17'sd4095)       return 13'sd4095;
    else if (x < -17'sd4096) return -13'sd4096;
    else                     return x[12:0];
  endfunction

  // ---------------- window counter ----------------
  logic       strb_q;
  logic [9:0] cnt_q, cnt_d, thresh;
  logic       active_d;

  // cnt_d is the count belonging to the current clk: 0 on the rising clk,
  // then +1 per clk, saturating at 1023.
  always_comb begin
    thresh = b1_strobe[9] ? 10'd0 : b1_strobe;
    if (store_strb && !strb_q)  cnt_d = '0;
    else if (cnt_q == 10'd1023) cnt_d = cnt_q;
    else                        cnt_d = cnt_q + 10'd1;
    active_d = store_strb && (cnt_d >= thresh);
  end

  // ---------------- LUT storage and port B ----------------
  // Index order for all per-LUT arrays: 0 bpm1_i, 1 bpm1_q, 2 bpm2_i, 3 bpm2_q.
  logic [6:0]  lut_mem [4][32768];
  logic [6:0]  dinb [4];
  logic [14:0] addrb [4];
  logic        web [4];
  logic [6:0]  doutb_q [4];
  logic        slow_q;
  logic        b_edge;

  always_comb begin
    dinb[0]  = lut_bus.bpm1_i_lut_dinb;  dinb[1]  = lut_bus.bpm1_q_lut_dinb;
    dinb[2]  = lut_bus.bpm2_i_lut_dinb;  dinb[3]  = lut_bus.bpm2_q_lut_dinb;
    addrb[0] = lut_bus.bpm1_i_lut_addrb; addrb[1] = lut_bus.bpm1_q_lut_addrb;
    addrb[2] = lut_bus.bpm2_i_lut_addrb; addrb[3] = lut_bus.bpm2_q_lut_addrb;
    web[0]   = lut_bus.bpm1_i_lut_web;   web[1]   = lut_bus.bpm1_q_lut_web;
    web[2]   = lut_bus.bpm2_i_lut_web;   web[3]   = lut_bus.bpm2_q_lut_web;
  end

  assign lut_bus.bpm1_i_lut_doutb = doutb_q[0];
  assign lut_bus.bpm1_q_lut_doutb = doutb_q[1];
  assign lut_bus.bpm2_i_lut_doutb = doutb_q[2];
  assign lut_bus.bpm2_q_lut_doutb = doutb_q[3];

  assign b_edge = slow_clk && !slow_q;

  // Memory contents are never reset. Reads elsewhere in the same clk see the
  // pre-write data, which gives read-first behaviour on both ports.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst && b_edge && web[k]) lut_mem[k][addrb[k]] <= dinb[k];
    end
  end

  // ---------------- datapath registers ----------------
  logic signed [12:0] ai1_q, aq1_q, q1_q, q2_q, q3_q, q4_q;
  logic signed [12:0] ch1_q [4];
  logic signed [12:0] ch2_q [4];
  logic signed [6:0]  g_q [4];
  logic signed [19:0] p_q [4];
  logic signed [19:0] p_d [4];
  logic signed [21:0] s_q, s_d;
  logic               act1_q, act2_q, act3_q, act4_q;
  logic [1:0]         sel1_q, sel2_q, sel3_q, sel4_q;
  logic [14:0]        addr1;
  logic signed [16:0] sh;
  logic signed [12:0] f_val, fq_val, v5;
  logic signed [12:0] dly_q [4];
  logic signed [12:0] fb_q;
  logic               unused_addr_bits;

  assign addr1 = {ai1_q[12:5], aq1_q[12:6]};
  assign unused_addr_bits = ^{ai1_q[4:0], aq1_q[5:0]};

  always_comb begin
    for (int k = 0; k < 4; k++) p_d[k] = 20'(ch2_q[k]) * 20'(g_q[k]);
    s_d = 22'(p_q[0]) + 22'(p_q[1]) + 22'(p_q[2]) + 22'(p_q[3]);
    // |S| < 2^21, so S >>> 6 always fits in 17 bits.
    sh     = 17'(s_q >>> 6);
    f_val  = sat13(sh);
    fq_val = sat13(17'(f_val) + 17'(q4_q));
    v5     = '0;
    if (act4_q) begin
      case (sel4_q)
        2'b01:   v5 = q4_q;
        2'b10:   v5 = f_val;
        2'b11:   v5 = fq_val;
        default: v5 = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strb_q <= 1'b0;
      cnt_q  <= '0;
      slow_q <= 1'b0;
      ai1_q  <= '0;  aq1_q  <= '0;
      q1_q   <= '0;  q2_q   <= '0;  q3_q   <= '0;  q4_q   <= '0;
      act1_q <= 1'b0; act2_q <= 1'b0; act3_q <= 1'b0; act4_q <= 1'b0;
      sel1_q <= '0;  sel2_q <= '0;  sel3_q <= '0;  sel4_q <= '0;
      s_q    <= '0;
      fb_q   <= '0;
      for (int k = 0; k < 4; k++) begin
        ch1_q[k]   <= '0;
        ch2_q[k]   <= '0;
        g_q[k]     <= '0;
        p_q[k]     <= '0;
        dly_q[k]   <= '0;
        doutb_q[k] <= '0;
      end
    end else begin
      strb_q <= store_strb;
      if (store_strb) cnt_q <= cnt_d;
      slow_q <= slow_clk;
      // stage 1
      ai1_q    <= ai_in;
      aq1_q    <= aq_in;
      ch1_q[0] <= bi_in;
      ch1_q[1] <= bq_in;
      ch1_q[2] <= ci_in;
      ch1_q[3] <= cq_in;
      q1_q     <= q_signal;
      act1_q   <= active_d;
      sel1_q   <= sel;
      // stages 2..4
      q2_q <= q1_q;     q3_q <= q2_q;     q4_q <= q3_q;
      act2_q <= act1_q; act3_q <= act2_q; act4_q <= act3_q;
      sel2_q <= sel1_q; sel3_q <= sel2_q; sel4_q <= sel3_q;
      s_q <= s_d;
      for (int k = 0; k < 4; k++) begin
        ch2_q[k] <= ch1_q[k];
        g_q[k]   <= lut_mem[k][addr1];
        p_q[k]   <= p_d[k];
        if (b_edge) doutb_q[k] <= lut_mem[k][addrb[k]];
      end
      // stage 5 and optional 4-deep delay
      dly_q[0] <= v5;
      dly_q[1] <= dly_q[0];
      dly_q[2] <= dly_q[1];
      dly_q[3] <= dly_q[2];
      fb_q     <= delay_en ? dly_q[3] : v5;
    end
  end

  assign fb_sgnl = fb_q;

endmodule

// File: tb/tb_fb_module.sv
// tb_fb_module: self-checking bench for fb_module. A behavioural model turns
// each cycle's inputs into the expected output value; an expected queue
// delays that by the pipeline depth before comparing with fb_sgnl.
module tb_fb_module;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, slow_clk, store_strb, delay_en;
  logic [1:0]         sel;
  logic signed [12:0] ai, aq, bi, bq, ci, cq, q_sig;
  logic signed [9:0]  b1;
  logic signed [12:0] fb_sgnl;

  fb_module_if bus();

  fb_module dut (
    .clk(clk), .rst(rst), .slow_clk(slow_clk), .sel(sel),
    .ai_in(ai), .aq_in(aq), .bi_in(bi), .bq_in(bq), .ci_in(ci), .cq_in(cq),
    .q_signal(q_sig), .store_strb(store_strb), .b1_strobe(b1),
    .delay_en(delay_en), .lut_bus(bus), .fb_sgnl(fb_sgnl)
  );

  // ---------------- scoreboard / model state ----------------
  logic [12:0] exp_q[$];
  logic [6:0]  lut_m [int];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          strb_prev = 1'b0;
  int          win_cnt = 0;

  function automatic int depth();
    return delay_en ? 9 : 5;
  endfunction

  function automatic int sat13i(input int x);
    if (x > 4095)  return 4095;
    if (x < -4096) return -4096;
    return x;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_port(input int k, input logic [14:0] a, input logic [6:0] d, input bit we);
    case (k)
      0: begin bus.bpm1_i_lut_addrb = a; bus.bpm1_i_lut_dinb = d; bus.bpm1_i_lut_web = we; end
      1: begin bus.bpm1_q_lut_addrb = a; bus.bpm1_q_lut_dinb = d; bus.bpm1_q_lut_web = we; end
      2: begin bus.bpm2_i_lut_addrb = a; bus.bpm2_i_lut_dinb = d; bus.bpm2_i_lut_web = we; end
      default: begin bus.bpm2_q_lut_addrb = a; bus.bpm2_q_lut_dinb = d; bus.bpm2_q_lut_web = we; end
    endcase
  endtask

  function automatic logic [6:0] get_dout(input int k);
    case (k)
      0:       return bus.bpm1_i_lut_doutb;
      1:       return bus.bpm1_q_lut_doutb;
      2:       return bus.bpm2_i_lut_doutb;
      default: return bus.bpm2_q_lut_doutb;
    endcase
  endfunction

  // One port-B access on LUT k: slow_clk low for a clk, then high for a clk.
  task automatic lut_access(input int k, input logic [14:0] a, input logic [6:0] d,
                            input bit we, output logic [6:0] dout);
    for (int j = 0; j < 4; j++) set_port(j, 15'd0, 7'd0, 1'b0);
    set_port(k, a, d, we);
    slow_clk = 1'b0;
    @(posedge clk); #1;
    slow_clk = 1'b1;
    @(posedge clk); #1;
    dout = get_dout(k);
    slow_clk = 1'b0;
    set_port(k, a, d, 1'b0);
    if (we) lut_m[k * 32768 + int'(a)] = d;
  endtask

  // Idle the window long enough to empty every pipeline/delay register.
  task automatic flush();
    store_strb = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    exp_q.delete();
    repeat (depth() - 1) exp_q.push_back(13'd0);
    strb_prev = 1'b0;
  endtask

  // Model the current inputs, advance one clk, return the matured expectation.
  task automatic step(output bit valid, output logic signed [12:0] got,
                      output logic signed [12:0] exp);
    logic signed [12:0] e;
    logic signed [6:0]  gv;
    int g [4];
    int lim, s, f, key;
    bit act;
    if (store_strb && !strb_prev)        win_cnt = 0;
    else if (store_strb && win_cnt < 1023) win_cnt++;
    strb_prev = store_strb;
    lim = (b1 < 0) ? 0 : int'(b1);
    act = store_strb && (win_cnt >= lim);
    e = 13'sd0;
    if (act && sel == 2'b01) e = q_sig;
    else if (act && sel[1]) begin
      for (int k = 0; k < 4; k++) begin
        key = k * 32768 + int'({ai[12:5], aq[12:6]});
        gv = lut_m.exists(key) ? lut_m[key] : 7'd0;
        g[k] = gv;
      end
      s = int'(bi) * g[0] + int'(bq) * g[1] + int'(ci) * g[2] + int'(cq) * g[3];
      f = sat13i(s >>> 6);
      e = (sel == 2'b10) ? 13'(f) : 13'(sat13i(f + int'(q_sig)));
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
    got = fb_sgnl;
    valid = 1'b0;
    exp = 13'sd0;
    if (exp_q.size() == depth()) begin
      valid = 1'b1;
      exp = exp_q.pop_front();
    end
  endtask

  task automatic set_chan(input logic signed [12:0] v_bi, input logic signed [12:0] v_bq,
                          input logic signed [12:0] v_ci, input logic signed [12:0] v_cq);
    bi = v_bi; bq = v_bq; ci = v_ci; cq = v_cq;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (fb_sgnl !== 13'sd0) begin
      n_errors++; $display("FAIL reset_fb: got %0d expected 0", fb_sgnl);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (get_dout(k) !== 7'd0) begin
        n_errors++; $display("FAIL reset_doutb[%0d]: got %0h expected 0", k, get_dout(k));
      end
    end
    rst = 1'b0;
    flush();
  endtask

  task automatic test_port_b();
    logic [6:0] d, want;
    logic [6:0] init [4];
    init[0] = 7'h11; init[1] = 7'h22; init[2] = 7'h33; init[3] = 7'h44;
    for (int k = 0; k < 4; k++) lut_access(k, 15'h1234, init[k], 1'b1, d);
    // read-first: the write returns the old contents
    want = lut_m[0 * 32768 + 'h1234];
    lut_access(0, 15'h1234, 7'h55, 1'b1, d);
    n_checks++;
    if (d !== want) begin
      n_errors++; $display("FAIL portb_read_first: got %0h expected %0h", d, want);
    end
    for (int k = 0; k < 4; k++) begin
      lut_access(k, 15'h1234, 7'h00, 1'b0, d);
      want = (k == 0) ? 7'h55 : init[k];
      n_checks++;
      if (d !== want) begin
        n_errors++; $display("FAIL portb_read[%0d]: got %0h expected %0h", k, d, want);
      end
    end
    // no slow_clk edge: doutb holds even when the address moves
    set_port(3, 15'h0001, 7'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (get_dout(3) !== 7'h44) begin
      n_errors++; $display("FAIL portb_hold: got %0h expected 44", get_dout(3));
    end
  endtask

  task automatic load_gains(input logic [6:0] g0, input logic [6:0] g1,
                            input logic [6:0] g2, input logic [6:0] g3);
    logic [6:0] d;
    lut_access(0, 15'd0, g0, 1'b1, d);
    lut_access(1, 15'd0, g1, 1'b1, d);
    lut_access(2, 15'd0, g2, 1'b1, d);
    lut_access(3, 15'd0, g3, 1'b1, d);
  endtask

  // Hold inputs for n clks from a fresh window; check every matured sample and
  // the fixed value "want" on the sample after edge number "at" (1-based).
  task automatic run_hold(input string name, input int n, input int at,
                          input logic signed [12:0] want);
    bit v; logic signed [12:0] got, exp;
    store_strb = 1'b1;
    for (int i = 1; i <= n; i++) begin
      step(v, got, exp);
      if (v) begin
        n_checks++;
        if (got !== exp) begin
          n_errors++; $display("FAIL %s model edge %0d: got %0d expected %0d", name, i, got, exp);
        end
      end
      if (i == at) begin
        n_checks++;
        if (got !== want) begin
          n_errors++; $display("FAIL %s value edge %0d: got %0d expected %0d", name, i, got, want);
        end
      end
    end
    flush();
  endtask

  task automatic test_gain();
    load_gains(7'd32, 7'd0, 7'd0, 7'd0);
    sel = 2'b10; b1 = 10'sd0; ai = 0; aq = 0; q_sig = 0;
    set_chan(13'sd100, 13'sd0, 13'sd0, 13'sd0);
    delay_en = 1'b0; flush();
    run_hold("gain_d0_early", 10, 4, 13'sd0);
    run_hold("gain_d0", 10, 5, 13'sd50);
    delay_en = 1'b1; flush();
    run_hold("gain_d1_early", 14, 8, 13'sd0);
    run_hold("gain_d1", 14, 9, 13'sd50);
    delay_en = 1'b0; flush();
  endtask

  task automatic test_saturation();
    load_gains(7'd63, 7'd63, 7'd63, 7'd63);
    sel = 2'b10; b1 = 10'sd0; ai = 0; aq = 0; q_sig = 0;
    flush();
    set_chan(13'sd4095, 13'sd4095, 13'sd4095, 13'sd4095);
    run_hold("sat_pos", 8, 8, 13'sd4095);
    set_chan(-13'sd4096, -13'sd4096, -13'sd4096, -13'sd4096);
    run_hold("sat_neg", 8, 8, -13'sd4096);
  endtask

  task automatic test_modes();
    load_gains(7'd32, 7'd0, 7'd0, 7'd0);
    b1 = 10'sd0; ai = 0; aq = 0; q_sig = -13'sd1234;
    set_chan(13'sd100, 13'sd0, 13'sd0, 13'sd0);
    flush();
    sel = 2'b01; run_hold("mode_01", 8, 8, -13'sd1234);
    sel = 2'b00; run_hold("mode_00", 8, 8, 13'sd0);
    sel = 2'b11; run_hold("mode_11", 8, 8, -13'sd1184);
    sel = 2'b10; run_hold("mode_10", 8, 8, 13'sd50);
  endtask

  // Count edges (including the one that first samples store_strb high) until
  // fb_sgnl first becomes nonzero; every sample also goes through the model.
  task automatic edges_to_nonzero(input string name, output int edges);
    bit v; logic signed [12:0] got, exp;
    edges = -1;
    store_strb = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step(v, got, exp);
      if (v) begin
        n_checks++;
        if (got !== exp) begin
          n_errors++; $display("FAIL %s model edge %0d: got %0d expected %0d", name, i, got, exp);
        end
      end
      if (edges < 0 && got !== 13'sd0) edges = i;
    end
  endtask

  task automatic test_window();
    bit v; logic signed [12:0] got, exp;
    int edges;
    sel = 2'b10; ai = 0; aq = 0; q_sig = 0;
    set_chan(13'sd100, 13'sd0, 13'sd0, 13'sd0);
    b1 = 10'sd25; flush();
    edges_to_nonzero("win25", edges);
    n_checks++;
    if (edges !== 30) begin
      n_errors++; $display("FAIL win25_start: got %0d edges expected 30", edges);
    end
    // falling edge of the window: zero after five edges
    store_strb = 1'b0;
    edges = -1;
    for (int i = 1; i <= 10; i++) begin
      step(v, got, exp);
      if (v) begin
        n_checks++;
        if (got !== exp) begin
          n_errors++; $display("FAIL win_fall model edge %0d: got %0d expected %0d", i, got, exp);
        end
      end
      if (edges < 0 && got === 13'sd0) edges = i;
    end
    n_checks++;
    if (edges !== 5) begin
      n_errors++; $display("FAIL win_fall_zero: got %0d edges expected 5", edges);
    end
    b1 = -10'sd3; flush();
    edges_to_nonzero("win_neg", edges);
    n_checks++;
    if (edges !== 5) begin
      n_errors++; $display("FAIL win_neg_start: got %0d edges expected 5", edges);
    end
    flush();
  endtask

  task automatic test_random(input bit de);
    bit v; logic signed [12:0] got, exp;
    logic [14:0] addrs [8];
    logic [14:0] a;
    logic [6:0]  d;
    int t;
    for (int i = 0; i < 8; i++) begin
      addrs[i] = 15'($urandom_range(0, 32767));
      for (int k = 0; k < 4; k++) lut_access(k, addrs[i], 7'($urandom_range(0, 127)), 1'b1, d);
    end
    delay_en = de; flush();
    t = $urandom_range(0, 30);
    b1 = 10'(t - 5);
    store_strb = 1'b1;
    for (int s = 0; s < 400; s++) begin
      sel = 2'($urandom_range(0, 3));
      a = addrs[$urandom_range(0, 7)];
      ai = {a[14:7], 5'($urandom_range(0, 31))};
      aq = {a[6:0], 6'($urandom_range(0, 63))};
      set_chan(13'($urandom), 13'($urandom), 13'($urandom), 13'($urandom));
      q_sig = 13'($urandom);
      if ($urandom_range(0, 29) == 0) store_strb = ~store_strb;
      step(v, got, exp);
      if (v) begin
        n_checks++;
        if (got !== exp) begin
          n_errors++; $display("FAIL random_d%0d step %0d: got %0d expected %0d", de, s, got, exp);
        end
      end
    end
    delay_en = 1'b0; flush();
  endtask

  task automatic test_reset_mid();
    bit v; logic signed [12:0] got, exp;
    int edges;
    load_gains(7'd32, 7'd0, 7'd0, 7'd0);
    sel = 2'b10; b1 = 10'sd0; ai = 0; aq = 0; q_sig = 0;
    set_chan(13'sd100, 13'sd0, 13'sd0, 13'sd0);
    flush();
    store_strb = 1'b1;
    for (int i = 0; i < 10; i++) step(v, got, exp);
    n_checks++;
    if (got !== 13'sd50) begin
      n_errors++; $display("FAIL rst_mid_pre: got %0d expected 50", got);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (fb_sgnl !== 13'sd0) begin
      n_errors++; $display("FAIL rst_mid_fb: got %0d expected 0", fb_sgnl);
    end
    rst = 1'b0;
    exp_q.delete();
    repeat (depth() - 1) exp_q.push_back(13'd0);
    strb_prev = 1'b0;
    // store_strb stays high: the first clk after reset opens a new window
    b1 = 10'sd10;
    edges_to_nonzero("rst_restart", edges);
    n_checks++;
    if (edges !== 15) begin
      n_errors++; $display("FAIL rst_restart_start: got %0d edges expected 15", edges);
    end
    flush();
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst = 1'b1; slow_clk = 1'b0; store_strb = 1'b0; delay_en = 1'b0;
    sel = 2'b00; b1 = 10'sd0; q_sig = 0; ai = 0; aq = 0;
    set_chan(13'sd0, 13'sd0, 13'sd0, 13'sd0);
    for (int k = 0; k < 4; k++) set_port(k, 15'd0, 7'd0, 1'b0);
    test_reset();
    test_port_b();
    test_gain();
    test_saturation();
    test_modes();
    test_window();
    test_random(1'b0);
    test_random(1'b1);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
